// File: rtl/cic_comp_fir.sv
// ---------------------------------------------------------------------------
// cic_comp_fir
//
// Droop-compensation FIR for the output of a 3-stage, R=32 CIC decimator.
// It runs at the decimated sample rate with the 5-tap symmetric kernel
// h = {1, -6, 26, -6, 1}. The kernel has a DC gain of 16, and an arithmetic
// shift right by SHIFT restores unity gain.
//
// A new sample arrives at most once every 32 clocks. The filter therefore
// uses a single multiply-accumulate and reuses it over five consecutive
// clocks, one tap per clock. A small FSM (IDLE -> MAC -> OUT) sequences this.
//
// Ports
//   clk      : system clock, the same clock as the CIC integrators
//   reset    : asynchronous, active-high; clears all state
//   x_in     : signed W_IN-bit sample from the CIC, taken when x_valid=1
//   x_valid  : one-cycle sample strobe
//   y_out    : signed W_OUT-bit result, rounded and saturated, held between strobes
//   y_valid  : one-cycle strobe, high in the cycle where y_out is new
//   busy     : high while a MAC sequence runs (MAC and OUT states)
//   overrun  : sticky; set when a strobe arrives while busy, cleared by reset
//
// Timing: a strobe on edge k is accumulated on edges k+1..k+5, and y_out
// updates on edge k+6. A strobe that arrives while busy is dropped.
// ---------------------------------------------------------------------------
module cic_comp_fir #(
  parameter int W_IN  = 10,
  parameter int W_OUT = 10,
  parameter int SHIFT = 4,
  parameter int W_ACC = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W_IN-1:0]  x_in,
  input  logic                    x_valid,
  output logic signed [W_OUT-1:0] y_out,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int W_COEF = 6;
  localparam int W_PROD = W_IN + W_COEF;
  localparam int NTAPS  = 5;

  // Rounding offset and saturation bounds, one bit wider than the
  // accumulator so that adding the offset can never wrap.
  localparam logic signed [W_ACC:0] HALF = (W_ACC+1)'(2 ** (SHIFT - 1));
  localparam logic signed [W_ACC:0] MAXV = (W_ACC+1)'(2 ** (W_OUT - 1) - 1);
  localparam logic signed [W_ACC:0] MINV = (W_ACC+1)'(-(2 ** (W_OUT - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Coefficient for each tap. The kernel is symmetric, so the order in which
  // the delay line is walked does not change the result.
  function automatic logic signed [W_COEF-1:0] coef(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd4: coef = 6'sd1;
      3'd1, 3'd3: coef = -6'sd6;
      3'd2:       coef = 6'sd26;
      default:    coef = 6'sd0;
    endcase
  endfunction

  // Round half toward +inf, i.e. (a + 2^(SHIFT-1)) >>> SHIFT, then clamp to
  // the signed W_OUT range.
  function automatic logic signed [W_OUT-1:0] sat_round(input logic signed [W_ACC-1:0] a);
    logic signed [W_ACC:0] t;
    t = (W_ACC+1)'(a) + HALF;
    t = t >>> SHIFT;
    if (t > MAXV) begin
      sat_round = MAXV[W_OUT-1:0];
    end else if (t < MINV) begin
      sat_round = MINV[W_OUT-1:0];
    end else begin
      sat_round = t[W_OUT-1:0];
    end
  endfunction

  state_t                    state_q, state_d;
  logic signed [W_IN-1:0]    dly_q [NTAPS];
  logic signed [W_IN-1:0]    dly_d [NTAPS];
  logic signed [W_ACC-1:0]   acc_q, acc_d;
  logic [2:0]                idx_q, idx_d;
  logic signed [W_OUT-1:0]   y_q, y_d;
  logic                      yv_q, yv_d;
  logic                      ovr_q, ovr_d;

  logic signed [W_IN-1:0]    tap;
  logic signed [W_PROD-1:0]  prod;

  // Tap select and exact product for the current MAC step. Both operands
  // are widened to the full product width, so the multiply cannot overflow.
  always_comb begin
    tap = '0;
    case (idx_q)
      3'd0:    tap = dly_q[0];
      3'd1:    tap = dly_q[1];
      3'd2:    tap = dly_q[2];
      3'd3:    tap = dly_q[3];
      3'd4:    tap = dly_q[4];
      default: tap = '0;
    endcase
    prod = W_PROD'(coef(idx_q)) * W_PROD'(tap);
  end

  // Next-state logic for the sequencer and the datapath registers.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        if (x_valid) begin
          dly_d[0] = x_in;
          for (int i = 1; i < NTAPS; i++) begin
            dly_d[i] = dly_q[i-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + W_ACC'(prod);
        if (idx_q == 3'(NTAPS - 1)) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      OUT: begin
        y_d     = sat_round(acc_q);
        yv_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe that arrives mid-sequence is lost. Record the event so that
    // software can detect the upstream rate violation.
    if (x_valid && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NTAPS; i++) begin
        dly_q[i] <= '0;
      end
      acc_q <= '0;
      idx_q <= '0;
      y_q   <= '0;
      yv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NTAPS; i++) begin
        dly_q[i] <= dly_d[i];
      end
      acc_q <= acc_d;
      idx_q <= idx_d;
      y_q   <= y_d;
      yv_q  <= yv_d;
      ovr_q <= ovr_d;
    end
  end

  assign y_out   = y_q;
  assign y_valid = yv_q;
  assign busy    = (state_q != IDLE);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
module tb_cic_comp_fir;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [9:0] x_in = '0;
  logic              x_valid = 1'b0;
  logic signed [9:0] y_out;
  logic              y_valid;
  logic              busy;
  logic              overrun;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cic_comp_fir #(
    .W_IN (10),
    .W_OUT(10),
    .SHIFT(4),
    .W_ACC(18)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .x_in   (x_in),
    .x_valid(x_valid),
    .y_out  (y_out),
    .y_valid(y_valid),
    .busy   (busy),
    .overrun(overrun)
  );

  // Reference model: history of accepted samples, newest first.
  int hist[5];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_round_sat(input int acc);
    int r, q;
    r = acc + 8;
    q = (r >= 0) ? (r / 16) : -((-r + 15) / 16);  // floor division by 16
    if (q > 511) q = 511;
    if (q < -512) q = -512;
    return q;
  endfunction

  function automatic int model_push(input int x);
    int acc;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    acc = hist[0] + hist[4] - 6 * (hist[1] + hist[3]) + 26 * hist[2];
    return ref_round_sat(acc);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) hist[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Strobe one sample, then watch the next 8 edges. This records the result,
  // the latency to y_valid, the number of busy cycles and the number of
  // y_valid pulses.
  task automatic run_sample(input int x, output int y, output int lat,
                            output int bcnt, output int pulses);
    @(negedge clk);
    x_in    = x[9:0];
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    y = 0; lat = -1; bcnt = 0; pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      if (y_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          y   = int'(y_out);
        end
      end
    end
  endtask

  typedef struct {
    bit rst;
    int x;
    int y;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int y, lat, b, p, e, x, r;

    // Impulse of 16, then zeros
    vecs.push_back('{1, 16, 1});
    vecs.push_back('{0, 0, -6});
    vecs.push_back('{0, 0, 26});
    vecs.push_back('{0, 0, -6});
    vecs.push_back('{0, 0, 1});
    vecs.push_back('{0, 0, 0});
    // Rounding: impulse of 1
    vecs.push_back('{1, 1, 0});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{0, 0, 2});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{0, 0, 0});
    // DC step of 100: 100, -500, 2100, 1500, 1600 before rounding
    vecs.push_back('{1, 100, 6});
    vecs.push_back('{0, 100, -31});
    vecs.push_back('{0, 100, 131});
    vecs.push_back('{0, 100, 94});
    vecs.push_back('{0, 100, 100});
    vecs.push_back('{0, 100, 100});

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_valid", int'(y_valid), 0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run_sample(vecs[i].x, y, lat, b, p);
      chk($sformatf("vec%0d_y", i), y, vecs[i].y);
      chk($sformatf("vec%0d_latency", i), lat, 6);
      chk($sformatf("vec%0d_busy_cycles", i), b, 6);
      chk($sformatf("vec%0d_pulses", i), p, 1);
      repeat (20) @(posedge clk);
    end

    // Saturation: alternating +511 / -512
    do_reset();
    for (int i = 0; i < 8; i++) begin
      x = (i % 2 == 0) ? 511 : -512;
      run_sample(x, y, lat, b, p);
      e = model_push(x);
      chk($sformatf("sat%0d_model", i), y, e);
      if (i >= 4) chk($sformatf("sat%0d_clamp", i), y, (i % 2 == 0) ? 511 : -512);
    end

    // Overrun: a second strobe 3 clocks after the first is dropped
    do_reset();
    chk("ovr_initial", int'(overrun), 0);
    @(negedge clk);
    x_in = 10'sd16; x_valid = 1'b1;
    @(posedge clk);                       // edge k
    #1 x_valid = 1'b0;
    repeat (2) @(posedge clk);            // edge k+2
    @(negedge clk);
    x_in = 10'sd100; x_valid = 1'b1;
    @(posedge clk);                       // edge k+3
    #1 x_valid = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_busy", int'(busy), 1);
    repeat (3) @(posedge clk);            // edge k+6
    #1;
    chk("ovr_first_valid", int'(y_valid), 1);
    chk("ovr_first_y", int'(y_out), 1);
    @(negedge clk);
    x_in = 10'sd0; x_valid = 1'b1;
    @(posedge clk);                       // edge k+7, accepted
    #1 x_valid = 1'b0;
    chk("ovr_accept_busy", int'(busy), 1);
    chk("ovr_valid_one_cycle", int'(y_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    repeat (6) @(posedge clk);            // edge k+13
    #1;
    chk("ovr_second_valid", int'(y_valid), 1);
    chk("ovr_second_y", int'(y_out), -6);

    // Asynchronous reset in the middle of a MAC sequence
    @(negedge clk);
    x_in = 10'sd80; x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_y_out", int'(y_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_y_valid", int'(y_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    p = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (y_valid) p++;
    end
    chk("arst_no_valid", p, 0);
    run_sample(160, y, lat, b, p);
    chk("arst_cleared_line_y", y, 10);
    chk("arst_cleared_line_lat", lat, 6);

    // Randomized samples against the reference model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) x = ($urandom_range(0, 1) == 1) ? 511 : -512;
      else        x = int'($urandom_range(0, 1023)) - 512;
      run_sample(x, y, lat, b, p);
      e = model_push(x);
      chk($sformatf("rnd%0d_y(x=%0d)", i, x), y, e);
      chk($sformatf("rnd%0d_latency", i), lat, 6);
      chk($sformatf("rnd%0d_pulses", i), p, 1);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
